// File: rtl/class_arbiter.sv
// Purpose: weighted round-robin merge of two first-word-fall-through class FIFOs into one stream.
// Latency: 1 cycle from pop to registered out/valid_out/class_out.
// Backpressure: af_down=1 suppresses every pop in the same cycle; the burst state is held.
module class_arbiter #(
    parameter int DATA_SIZE = 10,
    parameter int WEIGHT0   = 2,
    parameter int WEIGHT1   = 4,
    parameter int CNT_SIZE  = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [DATA_SIZE-1:0] in0,
    input  logic                 empty0,
    output logic                 pop0,
    input  logic [DATA_SIZE-1:0] in1,
    input  logic                 empty1,
    output logic                 pop1,
    input  logic                 af_down,
    output logic [DATA_SIZE-1:0] out,
    output logic                 valid_out,
    output logic                 class_out
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SERVE0 = 2'd1,
        SERVE1 = 2'd2
    } state_t;

    // Burst quotas in counter width so the comparisons are width-matched.
    localparam logic [CNT_SIZE-1:0] W0_C = CNT_SIZE'(WEIGHT0);
    localparam logic [CNT_SIZE-1:0] W1_C = CNT_SIZE'(WEIGHT1);
    localparam logic [CNT_SIZE-1:0] ONE_C = CNT_SIZE'(1);

    state_t                state_q, state_d;
    logic [CNT_SIZE-1:0]   cnt_q, cnt_d;
    logic [DATA_SIZE-1:0]  out_q, out_d;
    logic                  valid_q, valid_d;
    logic                  class_q, class_d;

    logic                  grant0;
    logic                  grant1;
    logic                  cont_burst;

    // Grant selection: continue the current burst while the quota allows,
    // otherwise prefer the other class, falling back to a restart of the same one.
    always_comb begin
        grant0     = 1'b0;
        grant1     = 1'b0;
        cont_burst = 1'b0;
        if (!af_down) begin
            unique case (state_q)
                IDLE: begin
                    if (!empty1) begin
                        grant1 = 1'b1;
                    end else if (!empty0) begin
                        grant0 = 1'b1;
                    end
                end
                SERVE0: begin
                    if (!empty0 && (cnt_q < W0_C)) begin
                        grant0     = 1'b1;
                        cont_burst = 1'b1;
                    end else if (!empty1) begin
                        grant1 = 1'b1;
                    end else if (!empty0) begin
                        grant0 = 1'b1;
                    end
                end
                SERVE1: begin
                    if (!empty1 && (cnt_q < W1_C)) begin
                        grant1     = 1'b1;
                        cont_burst = 1'b1;
                    end else if (!empty0) begin
                        grant0 = 1'b1;
                    end else if (!empty1) begin
                        grant1 = 1'b1;
                    end
                end
                default: begin
                    grant0 = 1'b0;
                    grant1 = 1'b0;
                end
            endcase
        end
    end

    // Pops follow the grants but are forced low while reset is asserted,
    // independent of any clock edge.
    assign pop0 = grant0 & reset;
    assign pop1 = grant1 & reset;

    // Next-state, burst counter and output register updates.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        out_d   = out_q;
        valid_d = 1'b0;
        class_d = class_q;
        if (grant0 || grant1) begin
            valid_d = 1'b1;
            class_d = grant1;
            out_d   = grant1 ? in1 : in0;
            if (cont_burst) begin
                cnt_d = cnt_q + ONE_C;
            end else begin
                state_d = grant1 ? SERVE1 : SERVE0;
                cnt_d   = ONE_C;
            end
        end else if (empty0 && empty1) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
        // Remaining case: blocked only by af_down, state and count hold.
        if (state_q != IDLE && state_q != SERVE0 && state_q != SERVE1) begin
            state_d = IDLE;
            cnt_d   = '0;
        end
    end

    // State and datapath registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            out_q   <= '0;
            valid_q <= 1'b0;
            class_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            out_q   <= out_d;
            valid_q <= valid_d;
            class_q <= class_d;
        end
    end

    assign out       = out_q;
    assign valid_out = valid_q;
    assign class_out = class_q;

endmodule

// File: tb/tb_class_arbiter.sv
module tb_class_arbiter;

    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset;
    logic [DW-1:0] in0, in1;
    logic          empty0, empty1;
    logic          pop0, pop1;
    logic          af_down;
    logic [DW-1:0] out;
    logic          valid_out;
    logic          class_out;

    logic [DW-1:0] q0[$];
    logic [DW-1:0] q1[$];
    logic [DW:0]   expq[$];
    int            checks = 0;
    int            errors = 0;

    always #5 clk = ~clk;

    class_arbiter #(
        .DATA_SIZE(DW),
        .WEIGHT0  (2),
        .WEIGHT1  (4),
        .CNT_SIZE (3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .in0      (in0),
        .empty0   (empty0),
        .pop0     (pop0),
        .in1      (in1),
        .empty1   (empty1),
        .pop1     (pop1),
        .af_down  (af_down),
        .out      (out),
        .valid_out(valid_out),
        .class_out(class_out)
    );

    function automatic void refresh();
        empty0 = (q0.size() == 0);
        empty1 = (q1.size() == 0);
        in0    = empty0 ? '0 : q0[0];
        in1    = empty1 ? '0 : q1[0];
    endfunction

    function automatic void load(input int cls, input int base, input int n);
        for (int i = 0; i < n; i++) begin
            if (cls == 0) q0.push_back(DW'(base + i));
            else          q1.push_back(DW'(base + i));
        end
        refresh();
    endfunction

    // One clock cycle: score the registered output, check pops against the
    // expected pattern character ('0', '1' or '-'), then advance the FIFO model.
    task automatic cycle(input byte c);
        logic [DW:0] e;
        logic p0, p1, ep0, ep1;
        @(negedge clk);
        p0 = pop0;
        p1 = pop1;
        checks++;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            if (valid_out !== 1'b1 || out !== e[DW-1:0] || class_out !== e[DW]) begin
                errors++;
                $display("FAIL out_word: got valid=%b class=%b data=%h, want valid=1 class=%b data=%h",
                         valid_out, class_out, out, e[DW], e[DW-1:0]);
            end
        end else if (valid_out !== 1'b0) begin
            errors++;
            $display("FAIL out_idle: got valid=%b, want valid=0", valid_out);
        end
        ep0 = (c == "0");
        ep1 = (c == "1");
        checks++;
        if ({p0, p1} !== {ep0, ep1}) begin
            errors++;
            $display("FAIL pops: got pop0=%b pop1=%b, want pop0=%b pop1=%b at %0t",
                     p0, p1, ep0, ep1, $time);
        end
        if (p0 === 1'b1) begin
            if (empty0) begin errors++; $display("FAIL pop0_empty: got pop of empty fifo, want none"); end
            else expq.push_back({1'b0, in0});
        end
        if (p1 === 1'b1) begin
            if (empty1) begin errors++; $display("FAIL pop1_empty: got pop of empty fifo, want none"); end
            else expq.push_back({1'b1, in1});
        end
        @(posedge clk);
        #1;
        if (p0 === 1'b1 && q0.size() != 0) void'(q0.pop_front());
        if (p1 === 1'b1 && q1.size() != 0) void'(q1.pop_front());
        refresh();
    endtask

    task automatic run(input string pat, input string af);
        for (int i = 0; i < pat.len(); i++) begin
            af_down = (af[i] == "1");
            cycle(pat[i]);
        end
        af_down = 1'b0;
    endtask

    task automatic apply_reset(input int n);
        reset   = 1'b0;
        af_down = 1'b0;
        expq.delete();
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            checks++;
            if ({pop0, pop1, valid_out, class_out} !== 4'b0000 || out !== '0) begin
                errors++;
                $display("FAIL reset_hold: got pop0=%b pop1=%b valid=%b class=%b out=%h, want all 0",
                         pop0, pop1, valid_out, class_out, out);
            end
            @(posedge clk);
            #1;
        end
        reset = 1'b1;
    endtask

    task automatic clear_fifos();
        q0.delete();
        q1.delete();
        refresh();
    endtask

    task automatic test_reset();
        load(0, 'h0AA, 3);
        load(1, 'h1BB, 3);
        apply_reset(6);
        clear_fifos();
    endtask

    task automatic test_wrr();
        load(1, 'h1A0, 8);
        load(0, 'h0F0, 4);
        run("111100111100--", "00000000000000");
    endtask

    task automatic test_single_class();
        clear_fifos();
        apply_reset(2);
        load(0, 'h001, 5);
        run("00000--", "0000000");
        // Back in IDLE: class 1 wins even though class 0 served last.
        load(0, 'h010, 1);
        load(1, 'h110, 1);
        run("10-", "000");
    endtask

    task automatic test_backpressure();
        clear_fifos();
        apply_reset(2);
        load(1, 'h2A0, 4);
        load(0, 'h0B0, 2);
        run("11---1100--", "00111000000");
    endtask

    task automatic test_class_empties();
        clear_fifos();
        apply_reset(2);
        load(1, 'h3C0, 2);
        load(0, 'h050, 4);
        run("1100", "0000");
        load(1, 'h3C2, 1);
        run("100--", "00000");
    endtask

    task automatic test_reset_mid_burst();
        clear_fifos();
        apply_reset(2);
        load(0, 'h070, 4);
        run("0", "0");
        load(1, 'h270, 3);
        reset = 1'b0;
        #1;
        checks++;
        if ({pop0, pop1, valid_out, class_out} !== 4'b0000 || out !== '0) begin
            errors++;
            $display("FAIL async_reset: got pop0=%b pop1=%b valid=%b class=%b out=%h, want all 0",
                     pop0, pop1, valid_out, class_out, out);
        end
        apply_reset(2);
        run("1", "0");
    endtask

    initial begin
        reset   = 1'b0;
        af_down = 1'b0;
        refresh();
        #1;
        test_reset();
        test_wrr();
        test_single_class();
        test_backpressure();
        test_class_empties();
        test_reset_mid_burst();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
